// File: rtl/l2norm_elem_packer.sv
// l2norm_elem_packer: packs one element per beat into LANES-wide beats, zero-padding each vector's final partial beat
module l2norm_elem_packer #(
  parameter int ELEM_W = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ELEM_W-1:0]         s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  output logic [ELEM_W*LANES-1:0]   m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [LANES*ELEM_W/8-1:0] m_tkeep,
  output logic                      m_tuser,
  output logic [CNT_W-1:0]          vec_count
);
  localparam int LW = $clog2(LANES);
  localparam int KB = ELEM_W / 8;
  logic [LANES-2:0][ELEM_W-1:0] asm_q, asm_d;
  logic [LANES-1:0][ELEM_W-1:0] beat;
  logic [LANES-1:0][KB-1:0] keep;
  logic [LANES-1:0] upto, below;
  logic [LW-1:0] lane;
  logic first, accept, complete;
  assign s_tready = !reset && (!m_tvalid || m_tready);
  assign accept = s_tvalid && s_tready;
  assign complete = accept && (s_tlast || lane == LW'(LANES-1));
  // thermometer masks: upto covers lanes 0..lane, below covers lanes 0..lane-1
  assign upto = (LANES'(2) << lane) - LANES'(1);
  assign below = upto >> 1;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ELEM_W-1:0] held;
    if (i < LANES-1) begin : g_asm
      assign held = asm_q[i];
      assign asm_d[i] = (accept && lane == LW'(i)) ? s_tdata : asm_q[i];
    end else begin : g_top
      assign held = '0;
    end
    assign beat[i] = below[i] ? held : upto[i] ? s_tdata : '0;
    assign keep[i] = {KB{upto[i]}};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      asm_q <= '0;
      lane <= '0;
      first <= 1'b1;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tkeep <= '0;
      m_tlast <= 1'b0;
      m_tuser <= 1'b0;
      vec_count <= '0;
    end else begin
      asm_q <= complete ? '0 : asm_d;
      lane <= complete ? '0 : accept ? lane + LW'(1) : lane;
      if (complete) begin
        first <= s_tlast;
        m_tdata <= beat;
        m_tkeep <= keep;
        m_tlast <= s_tlast;
        m_tuser <= first;
      end
      m_tvalid <= complete || (m_tvalid && !m_tready);
      if (m_tvalid && m_tready && m_tlast) vec_count <= vec_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_l2norm_elem_packer.sv
// tb_l2norm_elem_packer: scoreboard bench; expected beats come from chunking each vector into groups of four
module tb_l2norm_elem_packer;
  logic clock = 0, reset = 1;
  logic [15:0] s_tdata = '0;
  logic s_tvalid = 0, s_tlast = 0, m_tready = 1;
  logic s_tready, m_tvalid, m_tlast, m_tuser;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep;
  logic [15:0] vec_count;

  l2norm_elem_packer dut (
    .clock(clock), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .vec_count(vec_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u;} beat_t;
  beat_t exp_q[$];
  logic [15:0] vec[$];
  int vecs = 0, errs = 0, mode = 0;
  logic [15:0] exp_cnt = '0;
  beat_t held;
  bit stalled = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // m_tready: 0 = always ready, 1 = random, 2 = driven by the test
  initial forever begin
    @(posedge clock); #1;
    if (mode == 0) m_tready = 1;
    else if (mode == 1) m_tready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      exp_q.delete();
      exp_cnt = '0;
      stalled = 0;
    end else begin
      chk("vec_count", vec_count, exp_cnt);
      if (stalled) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, held.d);
        chk("hold_keep", m_tkeep, held.k);
        chk("hold_last", m_tlast, held.l);
        chk("hold_user", m_tuser, held.u);
      end
      if (m_tvalid && !m_tready) chk("stall_s_tready", s_tready, 0);
      stalled = m_tvalid && !m_tready;
      held = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_beat: got %h expected none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e.d);
          chk("beat_keep", m_tkeep, e.k);
          chk("beat_last", m_tlast, e.l);
          chk("beat_user", m_tuser, e.u);
          if (e.l) exp_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    bit acc = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    do begin
      @(negedge clock); acc = s_tready;
      @(posedge clock); #1; n++;
    end while (!acc && n < 200);
    if (!acc) begin
      vecs++; errs++;
      $display("FAIL send_timeout: got not accepted expected accepted");
    end
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic send_vec(input bit gaps);
    beat_t e;
    int n;
    for (int b = 0; b * 4 < vec.size(); b++) begin
      e = '0;
      for (int j = 0; j < 4; j++)
        if (b * 4 + j < vec.size()) begin
          e.d[j*16 +: 16] = vec[b*4+j];
          e.k[j*2 +: 2] = 2'b11;
        end
      e.l = (b * 4 + 4 >= vec.size());
      e.u = (b == 0);
      exp_q.push_back(e);
    end
    for (int k = 0; k < vec.size(); k++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge clock); #1; end
      end
      send(vec[k], k == vec.size() - 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clock); n++; end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint t0;
    int n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_keep", m_tkeep, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_user", m_tuser, 0);
    chk("rst_count", vec_count, 0);
    @(posedge clock); #1 reset = 0;

    vec = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    send_vec(0); drain();
    chk("full_count", vec_count, 1);

    vec = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    send_vec(0); drain();
    chk("pad_count", vec_count, 2);

    vec = {16'hFFFF};
    send_vec(0);
    @(negedge clock);
    chk("single_latency", m_tvalid, 1);
    @(posedge clock); #1;
    drain();
    chk("single_count", vec_count, 3);

    mode = 2; m_tready = 0;
    vec.delete();
    for (int i = 0; i < 12; i++) vec.push_back(16'($urandom));
    fork
      send_vec(0);
      begin
        n = 0;
        while (!m_tvalid && n < 100) begin @(negedge clock); n++; end
        chk("bp_first_valid", m_tvalid, 1);
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("bp_s_tready", s_tready, 0);
        repeat (5) @(posedge clock);
        #1 m_tready = 1;
      end
    join
    mode = 0;
    drain();
    chk("bp_count", vec_count, 4);

    send(16'h0101, 0);
    send(16'h0202, 0);
    do_reset();
    vec = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    send_vec(0); drain();
    chk("rstmid_count", vec_count, 1);

    do_reset();
    t0 = $time;
    for (int v = 0; v < 3; v++) begin
      vec.delete();
      for (int i = 0; i < 4; i++) vec.push_back(16'($urandom));
      send_vec(0);
    end
    chk("b2b_cycles", 64'(($time - t0) / 10), 12);
    drain();
    chk("b2b_count", vec_count, 3);

    mode = 1;
    for (int v = 0; v < 40; v++) begin
      vec.delete();
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) vec.push_back(16'($urandom));
      send_vec(1);
    end
    mode = 0;
    drain();
    chk("rand_count", vec_count, 43);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
